// File: rtl/autorange_gate_ctrl.sv
// autorange_gate_ctrl: gate sequencer for a 4-digit decade counter with automatic
// 1000/100/10/1 ms range selection and digit-register load strobe.
module autorange_gate_ctrl #(
    parameter int BASE_TICKS = 100000,
    parameter int HOLD_MS    = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       cnt_ovf,
    input  logic       msd_zero,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       reg_load,
    output logic [1:0] range,
    output logic [1:0] dp_pos,
    output logic       over_range,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, CLEAR, GATE, EVAL, LOAD, HOLD} state_t;
    localparam int PW = BASE_TICKS > 1 ? $clog2(BASE_TICKS) : 1;

    state_t        state;
    logic [PW-1:0] pre;
    logic [15:0]   ms;
    logic [15:0]   g;
    logic          ovf_seen;
    logic          pend;
    logic          tick_end;
    logic          gate_end;
    logic          hold_end;

    always_comb begin
        g        = range == 2'd0 ? 16'd1000 : range == 2'd1 ? 16'd100 : range == 2'd2 ? 16'd10 : 16'd1;
        tick_end = pre == PW'(BASE_TICKS - 1);
        gate_end = tick_end && ms == g - 16'd1;
        hold_end = tick_end && ms == 16'(HOLD_MS - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            range      <= 2'd3;
            dp_pos     <= 2'd3;
            over_range <= 1'b0;
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            reg_load   <= 1'b0;
            busy       <= 1'b0;
            pre        <= '0;
            ms         <= '0;
            ovf_seen   <= 1'b0;
            pend       <= 1'b0;
        end else begin
            cnt_clr  <= 1'b0;
            reg_load <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    state   <= CLEAR;
                    cnt_clr <= 1'b1;
                    busy    <= 1'b1;
                end
                CLEAR: begin
                    state    <= GATE;
                    cnt_en   <= 1'b1;
                    pre      <= '0;
                    ms       <= '0;
                    ovf_seen <= 1'b0;
                end
                GATE: begin
                    if (cnt_ovf) ovf_seen <= 1'b1;
                    pre <= tick_end ? '0 : pre + 1'b1;
                    ms  <= tick_end ? ms + 16'd1 : ms;
                    if (gate_end) begin
                        state  <= EVAL;
                        cnt_en <= 1'b0;
                    end
                end
                EVAL: begin
                    // Overflow outranks leading zero; shorter gate on overflow, longer on msd_zero
                    if (ovf_seen && range != 2'd3) begin
                        range   <= range + 2'd1;
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                    end else if (ovf_seen) begin
                        pend     <= 1'b1;
                        state    <= LOAD;
                        reg_load <= 1'b1;
                    end else if (msd_zero && range != 2'd0) begin
                        range   <= range - 2'd1;
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                    end else begin
                        pend     <= 1'b0;
                        state    <= LOAD;
                        reg_load <= 1'b1;
                    end
                end
                LOAD: begin
                    dp_pos     <= range;
                    over_range <= pend;
                    state      <= HOLD;
                    pre        <= '0;
                    ms         <= '0;
                end
                HOLD: begin
                    pre <= tick_end ? '0 : pre + 1'b1;
                    ms  <= tick_end ? ms + 16'd1 : ms;
                    if (hold_end) begin
                        state   <= run ? CLEAR : IDLE;
                        cnt_clr <= run;
                        busy    <= run;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_autorange_gate_ctrl.sv
// tb_autorange_gate_ctrl: directed checks of gating, auto-ranging, hold, stop and reset
// with BASE_TICKS=4, HOLD_MS=2.
module tb_autorange_gate_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       cnt_ovf = 1'b0;
    logic       msd_zero = 1'b0;
    logic       cnt_clr;
    logic       cnt_en;
    logic       reg_load;
    logic [1:0] range;
    logic [1:0] dp_pos;
    logic       over_range;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    int         overlaps = 0;
    int         len;
    int         nload;
    int         nclr;

    autorange_gate_ctrl #(.BASE_TICKS(4), .HOLD_MS(2)) dut (
        .clk(clk), .reset(reset), .run(run), .cnt_ovf(cnt_ovf), .msd_zero(msd_zero),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .reg_load(reg_load), .range(range),
        .dp_pos(dp_pos), .over_range(over_range), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ((cnt_clr && cnt_en) || (cnt_clr && reg_load) || (cnt_en && reg_load)) overlaps++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for the gate, then counts its length; returns in the EVAL cycle.
    task automatic gate(input int ovf_at, input int drop_at, output int n);
        int t = 0;
        while (!cnt_en && t < 10000) begin
            t++;
            step();
        end
        n = 0;
        while (cnt_en && n < 10000) begin
            n++;
            cnt_ovf = (n == ovf_at);
            if (n == drop_at) run = 1'b0;
            step();
        end
        cnt_ovf = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_range", 32'(range), 3);
        chk("rst_dp", 32'(dp_pos), 3);
        chk("rst_over", 32'(over_range), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'(cnt_en), 0);
        chk("rst_clr", 32'(cnt_clr), 0);
        chk("rst_load", 32'(reg_load), 0);

        // 1: basic measurement at 1 ms gate
        reset = 1'b0;
        run = 1'b1;
        step();
        chk("s1_clr", 32'(cnt_clr), 1);
        chk("s1_en_in_clr", 32'(cnt_en), 0);
        chk("s1_busy", 32'(busy), 1);
        gate(-1, -1, len);
        chk("s1_gate_len", 32'(len), 4);
        chk("s1_eval_load", 32'(reg_load), 0);
        step();
        chk("s1_load", 32'(reg_load), 1);
        step();
        chk("s1_load_1cyc", 32'(reg_load), 0);
        chk("s1_dp", 32'(dp_pos), 3);
        chk("s1_over", 32'(over_range), 0);
        repeat (7) step();
        chk("s1_hold_end_clr", 32'(cnt_clr), 0);
        step();
        chk("s1_restart_clr", 32'(cnt_clr), 1);

        // 2: leading zero walks range down to 0
        msd_zero = 1'b1;
        gate(-1, -1, len);
        chk("s2_len_r3", 32'(len), 4);
        step();
        chk("s2_clr_r2", 32'(cnt_clr), 1);
        chk("s2_noload_r2", 32'(reg_load), 0);
        chk("s2_range2", 32'(range), 2);
        gate(-1, -1, len);
        chk("s2_len_r2", 32'(len), 40);
        step();
        chk("s2_range1", 32'(range), 1);
        gate(-1, -1, len);
        chk("s2_len_r1", 32'(len), 400);
        step();
        chk("s2_range0", 32'(range), 0);
        chk("s2_clr_r0", 32'(cnt_clr), 1);
        gate(-1, -1, len);
        chk("s2_len_r0", 32'(len), 4000);
        step();
        chk("s2_load", 32'(reg_load), 1);
        chk("s2_dp_before", 32'(dp_pos), 3);
        step();
        chk("s2_dp_after", 32'(dp_pos), 0);

        // 3: one overflow pulse at range 0 steps up to range 1
        msd_zero = 1'b0;
        gate(100, -1, len);
        chk("s3_len_r0", 32'(len), 4000);
        step();
        chk("s3_noload", 32'(reg_load), 0);
        chk("s3_clr", 32'(cnt_clr), 1);
        chk("s3_range1", 32'(range), 1);
        gate(-1, -1, len);
        chk("s3_len_r1", 32'(len), 400);
        step();
        chk("s3_load", 32'(reg_load), 1);
        step();
        chk("s3_dp", 32'(dp_pos), 1);
        chk("s3_over", 32'(over_range), 0);

        // 6: reset mid-gate at range 1
        for (int t = 0; t < 100 && !cnt_en; t++) step();
        repeat (20) step();
        chk("s6_pre_range", 32'(range), 1);
        chk("s6_pre_en", 32'(cnt_en), 1);
        reset = 1'b1;
        run = 1'b0;
        step();
        chk("s6_en", 32'(cnt_en), 0);
        chk("s6_range", 32'(range), 3);
        chk("s6_dp", 32'(dp_pos), 3);
        chk("s6_busy", 32'(busy), 0);
        reset = 1'b0;
        nload = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (reg_load) nload++;
        end
        chk("s6_noload", 32'(nload), 0);

        // 4: overflow at 1 ms gate flags over-range
        run = 1'b1;
        gate(2, -1, len);
        chk("s4_len", 32'(len), 4);
        step();
        chk("s4_load", 32'(reg_load), 1);
        chk("s4_range", 32'(range), 3);
        step();
        chk("s4_over", 32'(over_range), 1);
        chk("s4_dp", 32'(dp_pos), 3);
        gate(-1, -1, len);
        step();
        chk("s4_clean_load", 32'(reg_load), 1);
        chk("s4_over_held", 32'(over_range), 1);
        step();
        chk("s4_over_clr", 32'(over_range), 0);

        // 5: dropping run mid-gate completes then idles
        gate(-1, 2, len);
        chk("s5_len", 32'(len), 4);
        step();
        chk("s5_load", 32'(reg_load), 1);
        step();
        repeat (7) step();
        chk("s5_busy_hold", 32'(busy), 1);
        step();
        chk("s5_idle_busy", 32'(busy), 0);
        nclr = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (cnt_clr) nclr++;
        end
        chk("s5_no_clr", 32'(nclr), 0);
        chk("s5_busy_end", 32'(busy), 0);

        chk("strobe_overlap", 32'(overlaps), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
